id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between instruction decode and execute, plus the EX-side
// operand forwarding network for a 5-stage RISC-V style core.
//
// The stage latches the decoded instruction. It then builds the two ALU
// operands combinationally. Each operand comes from the latched register-file
// value, or from a younger result still in flight in MEM or WB.
//
// Parameters
//   FWD_EN        1: MEM/WB forwarding and WB bypass enabled; 0: latched only
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   Stall, Flush  pipeline control (see update priority below)
//   ID_*          decoded instruction from the ID stage
//   MEM_*         MEM-stage write-back candidate (forwarding source)
//   WB_*          WB-stage write-back candidate (forwarding / bypass source)
//   Src_A, Src_B  ALU operands
//   ALUControl, ArithmLog                  registered ALU controls
//   EX_Valid, EX_RegWrite, EX_Rd, EX_PC    registered instruction state
//   EX_WriteData  forwarded rs2 value (store data)
//   ForwardA/B    operand source: 00 latched, 01 WB, 10 MEM
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned FWD_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        ID_Valid,
    input  logic [31:0] ID_RD1,
    input  logic [31:0] ID_RD2,
    input  logic [31:0] ID_Imm,
    input  logic [31:0] ID_PC,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic [4:0]  ID_Rd,
    input  logic [3:0]  ID_ALUControl,
    input  logic        ID_ArithmLog,
    input  logic [1:0]  ID_ALUSrcA,
    input  logic        ID_ALUSrcB,
    input  logic        ID_RegWrite,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_Rd,
    input  logic [31:0] MEM_ALUResult,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_Rd,
    input  logic [31:0] WB_Result,
    output logic [31:0] Src_A,
    output logic [31:0] Src_B,
    output logic [3:0]  ALUControl,
    output logic        ArithmLog,
    output logic        EX_Valid,
    output logic        EX_RegWrite,
    output logic [4:0]  EX_Rd,
    output logic [31:0] EX_PC,
    output logic [31:0] EX_WriteData,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB
);

    localparam logic FWD_ON = (FWD_EN != 0);

    // Pipeline control: there is no valid/ready handshake here. The hazard
    // unit drives Stall and Flush. On each edge the stage does exactly one of
    // these, in priority order: reset, flush (insert a bubble), stall (hold,
    // but keep absorbing WB results), load (capture ID).

    // EX-stage registers
    logic        valid_q,       valid_d;
    logic        reg_write_q,   reg_write_d;
    logic [4:0]  rd_q,          rd_d;
    logic [4:0]  rs1_q,         rs1_d;
    logic [4:0]  rs2_q,         rs2_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] rd1_q,         rd1_d;
    logic [31:0] rd2_q,         rd2_d;
    logic [31:0] imm_q,         imm_d;
    logic [3:0]  alu_control_q, alu_control_d;
    logic        arithm_log_q,  arithm_log_d;
    logic [1:0]  alu_src_a_q,   alu_src_a_d;
    logic        alu_src_b_q,   alu_src_b_d;

    // A write-back source "hits" a register index when it really writes,
    // targets a non-x0 register and matches the index. x0 never hits, so
    // reading x0 always returns the register file's zero.
    logic wb_hit_id_rs1, wb_hit_id_rs2;
    logic wb_hit_rs1,    wb_hit_rs2;
    logic mem_hit_rs1,   mem_hit_rs2;

    always_comb begin
        wb_hit_id_rs1 = FWD_ON && WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == ID_Rs1);
        wb_hit_id_rs2 = FWD_ON && WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == ID_Rs2);
        wb_hit_rs1    = FWD_ON && WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == rs1_q);
        wb_hit_rs2    = FWD_ON && WB_RegWrite && (WB_Rd != 5'd0) && (WB_Rd == rs2_q);
        mem_hit_rs1   = FWD_ON && MEM_RegWrite && (MEM_Rd != 5'd0) && (MEM_Rd == rs1_q);
        mem_hit_rs2   = FWD_ON && MEM_RegWrite && (MEM_Rd != 5'd0) && (MEM_Rd == rs2_q);
    end

    // Next-state selection
    always_comb begin
        valid_d       = valid_q;
        reg_write_d   = reg_write_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        pc_d          = pc_q;
        rd1_d         = rd1_q;
        rd2_d         = rd2_q;
        imm_d         = imm_q;
        alu_control_d = alu_control_q;
        arithm_log_d  = arithm_log_q;
        alu_src_a_d   = alu_src_a_q;
        alu_src_b_d   = alu_src_b_q;

        if (reset) begin
            valid_d       = 1'b0;
            reg_write_d   = 1'b0;
            rd_d          = 5'd0;
            rs1_d         = 5'd0;
            rs2_d         = 5'd0;
            pc_d          = 32'd0;
            rd1_d         = 32'd0;
            rd2_d         = 32'd0;
            imm_d         = 32'd0;
            alu_control_d = 4'd0;
            arithm_log_d  = 1'b0;
            alu_src_a_d   = 2'd0;
            alu_src_b_d   = 1'b0;
        end else if (Flush) begin
            // Bubble: only the fields that can cause side effects are
            // cleared; the datapath registers keep whatever they held.
            valid_d       = 1'b0;
            reg_write_d   = 1'b0;
            alu_control_d = 4'd0;
            arithm_log_d  = 1'b0;
        end else if (Stall) begin
            // A result retiring from WB during a stall would otherwise be
            // gone by the time the stall releases, so absorb it now.
            if (wb_hit_rs1) rd1_d = WB_Result;
            if (wb_hit_rs2) rd2_d = WB_Result;
        end else begin
            // The register file is written at the end of WB, so a same-cycle
            // read in ID still sees the old value; bypass it here.
            valid_d       = ID_Valid;
            reg_write_d   = ID_RegWrite && ID_Valid;
            rd_d          = ID_Rd;
            rs1_d         = ID_Rs1;
            rs2_d         = ID_Rs2;
            pc_d          = ID_PC;
            rd1_d         = wb_hit_id_rs1 ? WB_Result : ID_RD1;
            rd2_d         = wb_hit_id_rs2 ? WB_Result : ID_RD2;
            imm_d         = ID_Imm;
            alu_control_d = ID_ALUControl;
            arithm_log_d  = ID_ArithmLog;
            alu_src_a_d   = ID_ALUSrcA;
            alu_src_b_d   = ID_ALUSrcB;
        end
    end

    always_ff @(posedge clk) begin
        valid_q       <= valid_d;
        reg_write_q   <= reg_write_d;
        rd_q          <= rd_d;
        rs1_q         <= rs1_d;
        rs2_q         <= rs2_d;
        pc_q          <= pc_d;
        rd1_q         <= rd1_d;
        rd2_q         <= rd2_d;
        imm_q         <= imm_d;
        alu_control_q <= alu_control_d;
        arithm_log_q  <= arithm_log_d;
        alu_src_a_q   <= alu_src_a_d;
        alu_src_b_q   <= alu_src_b_d;
    end

    // Forwarding network: MEM is the younger producer and wins over WB.
    logic [31:0] fwd_rs1, fwd_rs2;

    always_comb begin
        if (mem_hit_rs1) begin
            ForwardA = 2'b10;
            fwd_rs1  = MEM_ALUResult;
        end else if (wb_hit_rs1) begin
            ForwardA = 2'b01;
            fwd_rs1  = WB_Result;
        end else begin
            ForwardA = 2'b00;
            fwd_rs1  = rd1_q;
        end

        if (mem_hit_rs2) begin
            ForwardB = 2'b10;
            fwd_rs2  = MEM_ALUResult;
        end else if (wb_hit_rs2) begin
            ForwardB = 2'b01;
            fwd_rs2  = WB_Result;
        end else begin
            ForwardB = 2'b00;
            fwd_rs2  = rd2_q;
        end
    end

    // Operand selection
    always_comb begin
        case (alu_src_a_q)
            2'b00:   Src_A = fwd_rs1;
            2'b01:   Src_A = pc_q;
            default: Src_A = 32'd0;   // LUI-style: zero base
        endcase
        Src_B = alu_src_b_q ? imm_q : fwd_rs2;
    end

    assign EX_WriteData = fwd_rs2;
    assign ALUControl   = alu_control_q;
    assign ArithmLog    = arithm_log_q;
    assign EX_Valid     = valid_q;
    assign EX_RegWrite  = reg_write_q;
    assign EX_Rd        = rd_q;
    assign EX_PC        = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage: directed tests for id_ex_stage. Two instances share all
// inputs: the default (forwarding on) and one built with FWD_EN=0.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT inputs
    logic        Stall, Flush, ID_Valid;
    logic [31:0] ID_RD1, ID_RD2, ID_Imm, ID_PC;
    logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd;
    logic [3:0]  ID_ALUControl;
    logic        ID_ArithmLog;
    logic [1:0]  ID_ALUSrcA;
    logic        ID_ALUSrcB, ID_RegWrite;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_Rd;
    logic [31:0] MEM_ALUResult;
    logic        WB_RegWrite;
    logic [4:0]  WB_Rd;
    logic [31:0] WB_Result;

    // Outputs, forwarding instance
    logic [31:0] Src_A, Src_B, EX_PC, EX_WriteData;
    logic [3:0]  ALUControl;
    logic        ArithmLog, EX_Valid, EX_RegWrite;
    logic [4:0]  EX_Rd;
    logic [1:0]  ForwardA, ForwardB;

    // Outputs, non-forwarding instance
    logic [31:0] nf_Src_A, nf_Src_B, nf_EX_PC, nf_EX_WriteData;
    logic [3:0]  nf_ALUControl;
    logic        nf_ArithmLog, nf_EX_Valid, nf_EX_RegWrite;
    logic [4:0]  nf_EX_Rd;
    logic [1:0]  nf_ForwardA, nf_ForwardB;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_ex_stage u_dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
        .ID_ALUControl(ID_ALUControl), .ID_ArithmLog(ID_ArithmLog),
        .ID_ALUSrcA(ID_ALUSrcA), .ID_ALUSrcB(ID_ALUSrcB), .ID_RegWrite(ID_RegWrite),
        .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_ALUResult(MEM_ALUResult),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Result(WB_Result),
        .Src_A(Src_A), .Src_B(Src_B), .ALUControl(ALUControl), .ArithmLog(ArithmLog),
        .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd), .EX_PC(EX_PC),
        .EX_WriteData(EX_WriteData), .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    id_ex_stage #(.FWD_EN(0)) u_dut_nofwd (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
        .ID_ALUControl(ID_ALUControl), .ID_ArithmLog(ID_ArithmLog),
        .ID_ALUSrcA(ID_ALUSrcA), .ID_ALUSrcB(ID_ALUSrcB), .ID_RegWrite(ID_RegWrite),
        .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_ALUResult(MEM_ALUResult),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Result(WB_Result),
        .Src_A(nf_Src_A), .Src_B(nf_Src_B), .ALUControl(nf_ALUControl),
        .ArithmLog(nf_ArithmLog), .EX_Valid(nf_EX_Valid), .EX_RegWrite(nf_EX_RegWrite),
        .EX_Rd(nf_EX_Rd), .EX_PC(nf_EX_PC), .EX_WriteData(nf_EX_WriteData),
        .ForwardA(nf_ForwardA), .ForwardB(nf_ForwardB)
    );

    // Driver tasks ----------------------------------------------------------
    // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
    // the edge, well clear of the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        MEM_RegWrite = 1'b0; MEM_Rd = 5'd0; MEM_ALUResult = 32'd0;
        WB_RegWrite  = 1'b0; WB_Rd  = 5'd0; WB_Result     = 32'd0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] ctrl, input logic al,
                          input logic [1:0] srca, input logic srcb,
                          input logic regw, input logic valid);
        ID_Rs1 = rs1; ID_Rs2 = rs2; ID_Rd = rd;
        ID_RD1 = rd1; ID_RD2 = rd2; ID_Imm = imm; ID_PC = pc;
        ID_ALUControl = ctrl; ID_ArithmLog = al;
        ID_ALUSrcA = srca; ID_ALUSrcB = srcb;
        ID_RegWrite = regw; ID_Valid = valid;
    endtask

    // Tests -----------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        clear_hazards();
        // Non-zero ID inputs prove reset beats load.
        set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 32'h44, 4'hF, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        total_cnt++; if (Src_A !== 32'd0) $display("FAIL reset_src_a got %h exp 0", Src_A); else pass_cnt++;
        total_cnt++; if (Src_B !== 32'd0) $display("FAIL reset_src_b got %h exp 0", Src_B); else pass_cnt++;
        total_cnt++; if (ALUControl !== 4'd0) $display("FAIL reset_aluctl got %h exp 0", ALUControl); else pass_cnt++;
        total_cnt++; if (ArithmLog !== 1'b0) $display("FAIL reset_arithmlog got %b exp 0", ArithmLog); else pass_cnt++;
        total_cnt++; if (EX_Valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", EX_Valid); else pass_cnt++;
        total_cnt++; if (EX_RegWrite !== 1'b0) $display("FAIL reset_regwrite got %b exp 0", EX_RegWrite); else pass_cnt++;
        total_cnt++; if (EX_Rd !== 5'd0) $display("FAIL reset_rd got %h exp 0", EX_Rd); else pass_cnt++;
        total_cnt++; if (EX_PC !== 32'd0) $display("FAIL reset_pc got %h exp 0", EX_PC); else pass_cnt++;
        total_cnt++; if (EX_WriteData !== 32'd0) $display("FAIL reset_wdata got %h exp 0", EX_WriteData); else pass_cnt++;
        total_cnt++; if ({ForwardA, ForwardB} !== 4'b0000) $display("FAIL reset_fwd got %b%b exp 0000", ForwardA, ForwardB); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_plain_load();
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h99, 32'h100, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        total_cnt++; if (Src_A !== 32'd5) $display("FAIL plain_src_a got %h exp 5", Src_A); else pass_cnt++;
        total_cnt++; if (Src_B !== 32'd7) $display("FAIL plain_src_b got %h exp 7", Src_B); else pass_cnt++;
        total_cnt++; if (EX_Valid !== 1'b1) $display("FAIL plain_valid got %b exp 1", EX_Valid); else pass_cnt++;
        total_cnt++; if (EX_RegWrite !== 1'b1) $display("FAIL plain_regwrite got %b exp 1", EX_RegWrite); else pass_cnt++;
        total_cnt++; if ({ForwardA, ForwardB} !== 4'b0000) $display("FAIL plain_fwd got %b%b exp 0000", ForwardA, ForwardB); else pass_cnt++;
        total_cnt++; if (EX_Rd !== 5'd3) $display("FAIL plain_rd got %h exp 3", EX_Rd); else pass_cnt++;
        total_cnt++; if (EX_PC !== 32'h100) $display("FAIL plain_pc got %h exp 100", EX_PC); else pass_cnt++;
        total_cnt++; if (EX_WriteData !== 32'd7) $display("FAIL plain_wdata got %h exp 7", EX_WriteData); else pass_cnt++;
    endtask

    task automatic test_alu_src();
        // PC as A, immediate as B; store data must still be rs2.
        set_id(5'd1, 5'd2, 5'd9, 32'h5, 32'h7, 32'hFFFF_FFF0, 32'h200, 4'b1010, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        tick();
        total_cnt++; if (Src_A !== 32'h200) $display("FAIL srca_pc got %h exp 200", Src_A); else pass_cnt++;
        total_cnt++; if (Src_B !== 32'hFFFF_FFF0) $display("FAIL srcb_imm got %h exp fffffff0", Src_B); else pass_cnt++;
        total_cnt++; if (EX_WriteData !== 32'h7) $display("FAIL wdata_rs2 got %h exp 7", EX_WriteData); else pass_cnt++;
        total_cnt++; if (ALUControl !== 4'b1010) $display("FAIL aluctl got %h exp a", ALUControl); else pass_cnt++;
        total_cnt++; if (ArithmLog !== 1'b1) $display("FAIL arithmlog got %b exp 1", ArithmLog); else pass_cnt++;
        // Zero as A.
        set_id(5'd1, 5'd2, 5'd9, 32'h5, 32'h7, 32'h3000, 32'h204, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1);
        tick();
        total_cnt++; if (Src_A !== 32'd0) $display("FAIL srca_zero got %h exp 0", Src_A); else pass_cnt++;
        total_cnt++; if (Src_B !== 32'h3000) $display("FAIL srca_zero_b got %h exp 3000", Src_B); else pass_cnt++;
    endtask

    task automatic test_priority();
        set_id(5'd3, 5'd2, 5'd8, 32'h11, 32'h22, 32'd0, 32'h300, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd3; MEM_ALUResult = 32'hAA;
        WB_RegWrite  = 1'b1; WB_Rd  = 5'd3; WB_Result     = 32'hBB;
        #1;
        total_cnt++; if (Src_A !== 32'hAA) $display("FAIL prio_mem_src_a got %h exp aa", Src_A); else pass_cnt++;
        total_cnt++; if (ForwardA !== 2'b10) $display("FAIL prio_mem_fwda got %b exp 10", ForwardA); else pass_cnt++;
        total_cnt++; if (ForwardB !== 2'b00) $display("FAIL prio_mem_fwdb got %b exp 00", ForwardB); else pass_cnt++;
        total_cnt++; if (nf_Src_A !== 32'h11) $display("FAIL nofwd_src_a got %h exp 11", nf_Src_A); else pass_cnt++;
        total_cnt++; if (nf_ForwardA !== 2'b00) $display("FAIL nofwd_fwda got %b exp 00", nf_ForwardA); else pass_cnt++;
        MEM_RegWrite = 1'b0;
        #1;
        total_cnt++; if (Src_A !== 32'hBB) $display("FAIL prio_wb_src_a got %h exp bb", Src_A); else pass_cnt++;
        total_cnt++; if (ForwardA !== 2'b01) $display("FAIL prio_wb_fwda got %b exp 01", ForwardA); else pass_cnt++;
        WB_RegWrite = 1'b0;
        #1;
        total_cnt++; if (Src_A !== 32'h11) $display("FAIL prio_none_src_a got %h exp 11", Src_A); else pass_cnt++;
        // MEM forwarding onto rs2 reaches both Src_B and store data.
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd2; MEM_ALUResult = 32'hCC;
        #1;
        total_cnt++; if (Src_B !== 32'hCC) $display("FAIL fwdb_mem_src_b got %h exp cc", Src_B); else pass_cnt++;
        total_cnt++; if (EX_WriteData !== 32'hCC) $display("FAIL fwdb_mem_wdata got %h exp cc", EX_WriteData); else pass_cnt++;
        total_cnt++; if (ForwardB !== 2'b10) $display("FAIL fwdb_mem got %b exp 10", ForwardB); else pass_cnt++;
        clear_hazards();
    endtask

    task automatic test_x0();
        set_id(5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, 32'h400, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd0; MEM_ALUResult = 32'h55;
        WB_RegWrite  = 1'b1; WB_Rd  = 5'd0; WB_Result     = 32'h66;
        #1;
        total_cnt++; if (Src_B !== 32'd0) $display("FAIL x0_src_b got %h exp 0", Src_B); else pass_cnt++;
        total_cnt++; if (ForwardB !== 2'b00) $display("FAIL x0_fwdb got %b exp 00", ForwardB); else pass_cnt++;
        total_cnt++; if (Src_A !== 32'd0) $display("FAIL x0_src_a got %h exp 0", Src_A); else pass_cnt++;
        clear_hazards();
    endtask

    task automatic test_load_bypass();
        // WB writes x6 on the same edge ID reads it.
        set_id(5'd6, 5'd2, 5'd7, 32'h1, 32'h2, 32'd0, 32'h500, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        WB_RegWrite = 1'b1; WB_Rd = 5'd6; WB_Result = 32'h66;
        tick();
        clear_hazards();
        #1;
        total_cnt++; if (Src_A !== 32'h66) $display("FAIL bypass_src_a got %h exp 66", Src_A); else pass_cnt++;
        total_cnt++; if (ForwardA !== 2'b00) $display("FAIL bypass_fwda got %b exp 00", ForwardA); else pass_cnt++;
        total_cnt++; if (nf_Src_A !== 32'h1) $display("FAIL nofwd_bypass got %h exp 1", nf_Src_A); else pass_cnt++;
    endtask

    task automatic test_stall_capture();
        set_id(5'd4, 5'd2, 5'd5, 32'h9, 32'h2, 32'd0, 32'h600, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        // Stall cycle 1: WB retires x4; ID presents unrelated junk.
        Stall = 1'b1;
        set_id(5'd9, 5'd9, 5'd31, 32'hDEAD, 32'hBEEF, 32'd0, 32'h700, 4'b0110, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        WB_RegWrite = 1'b1; WB_Rd = 5'd4; WB_Result = 32'h1234;
        #1;
        total_cnt++; if (Src_A !== 32'h1234) $display("FAIL stall_c1_src_a got %h exp 1234", Src_A); else pass_cnt++;
        total_cnt++; if (ForwardA !== 2'b01) $display("FAIL stall_c1_fwda got %b exp 01", ForwardA); else pass_cnt++;
        tick();
        clear_hazards();
        #1;
        total_cnt++; if (Src_A !== 32'h1234) $display("FAIL stall_c2_src_a got %h exp 1234", Src_A); else pass_cnt++;
        total_cnt++; if (ForwardA !== 2'b00) $display("FAIL stall_c2_fwda got %b exp 00", ForwardA); else pass_cnt++;
        total_cnt++; if (EX_Rd !== 5'd5) $display("FAIL stall_hold_rd got %h exp 5", EX_Rd); else pass_cnt++;
        tick();
        total_cnt++; if (Src_A !== 32'h1234) $display("FAIL stall_c3_src_a got %h exp 1234", Src_A); else pass_cnt++;
        total_cnt++; if (EX_PC !== 32'h600) $display("FAIL stall_hold_pc got %h exp 600", EX_PC); else pass_cnt++;
        total_cnt++; if (nf_Src_A !== 32'h9) $display("FAIL nofwd_stall got %h exp 9", nf_Src_A); else pass_cnt++;
        tick();
        Stall = 1'b0;
        #1;
        total_cnt++; if (Src_A !== 32'h1234) $display("FAIL stall_release_src_a got %h exp 1234", Src_A); else pass_cnt++;
    endtask

    task automatic test_flush();
        Stall = 1'b1; Flush = 1'b1;
        set_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'd0, 32'h800, 4'b0101, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        total_cnt++; if (EX_Valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", EX_Valid); else pass_cnt++;
        total_cnt++; if (EX_RegWrite !== 1'b0) $display("FAIL flush_regwrite got %b exp 0", EX_RegWrite); else pass_cnt++;
        total_cnt++; if (ALUControl !== 4'd0) $display("FAIL flush_aluctl got %h exp 0", ALUControl); else pass_cnt++;
        total_cnt++; if (ArithmLog !== 1'b0) $display("FAIL flush_arithmlog got %b exp 0", ArithmLog); else pass_cnt++;
        Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_invalid_load();
        set_id(5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'd0, 32'h900, 4'b0011, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        total_cnt++; if (EX_Valid !== 1'b0) $display("FAIL inval_valid got %b exp 0", EX_Valid); else pass_cnt++;
        total_cnt++; if (EX_RegWrite !== 1'b0) $display("FAIL inval_regwrite got %b exp 0", EX_RegWrite); else pass_cnt++;
        total_cnt++; if (Src_A !== 32'h77) $display("FAIL inval_src_a got %h exp 77", Src_A); else pass_cnt++;
        total_cnt++; if (ALUControl !== 4'b0011) $display("FAIL inval_aluctl got %h exp 3", ALUControl); else pass_cnt++;
    endtask

    task automatic test_reset_stall();
        set_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h12, 32'hA00, 4'b0111, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b1; Stall = 1'b1;
        tick();
        total_cnt++; if (Src_A !== 32'd0) $display("FAIL rststall_src_a got %h exp 0", Src_A); else pass_cnt++;
        total_cnt++; if (Src_B !== 32'd0) $display("FAIL rststall_src_b got %h exp 0", Src_B); else pass_cnt++;
        total_cnt++; if (EX_Valid !== 1'b0) $display("FAIL rststall_valid got %b exp 0", EX_Valid); else pass_cnt++;
        total_cnt++; if (EX_PC !== 32'd0) $display("FAIL rststall_pc got %h exp 0", EX_PC); else pass_cnt++;
        total_cnt++; if (ALUControl !== 4'd0) $display("FAIL rststall_aluctl got %h exp 0", ALUControl); else pass_cnt++;
        total_cnt++; if (EX_Rd !== 5'd0) $display("FAIL rststall_rd got %h exp 0", EX_Rd); else pass_cnt++;
        reset = 1'b0; Stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_alu_src();
        test_priority();
        test_x0();
        test_load_bypass();
        test_stall_capture();
        test_flush();
        test_invalid_load();
        test_reset_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
